// File: rtl/lobby_joltage_stream.sv
// rtl/lobby_joltage_stream.sv - streaming best-K-digit bank selector with running sum
//
// Purpose: digits of each bank arrive one per beat. The block keeps, for every
// j in 1..K, the largest j-digit subsequence value seen so far in the bank
// (best[j]). At end of bank best[K] is emitted and added to a running sum.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         pulse: clear state and begin a run (from IDLE or DONE)
//   s_valid       digit beat valid
//   s_ready       beat accepted when high (RUN only)
//   s_digit       BCD digit (values above 9 flag an error)
//   s_eol, s_eof  last digit of bank / last digit of the last bank
//   bank_valid    one-cycle pulse, bank_value valid
//   bank_value    best K-digit value of the completed bank (0 for a short bank)
//   result        running sum of bank values (wraps at ACC_W bits)
//   finished      high in DONE
//   error         sticky bad-digit / short-bank flag
module lobby_joltage_stream #(
  parameter int K     = 12,
  parameter int VAL_W = 40,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       s_digit,
  input  logic             s_eol,
  input  logic             s_eof,
  output logic             bank_valid,
  output logic [VAL_W-1:0] bank_value,
  output logic [ACC_W-1:0] result,
  output logic             finished,
  output logic             error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state;

  // best[0] is never written with anything but zero, so it acts as the
  // constant seed for the best[1] update.
  logic [VAL_W-1:0] best     [0:K];
  logic [VAL_W-1:0] best_nxt [0:K];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_after;

  logic             accept;
  logic             digit_ok;
  logic             short_bank;
  logic [VAL_W+3:0] prev_ext;
  logic [VAL_W+3:0] cand;

  assign accept   = s_valid && s_ready;
  assign digit_ok = (s_digit <= 4'd9);

  // Counter saturates so very long banks never wrap back below K.
  assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign cnt_after  = digit_ok ? cnt_inc : cnt;
  assign short_bank = (cnt_after < CNT_W'(K));

  // All best[j] update in parallel from pre-update values. best[j] may only
  // take a candidate once at least j-1 digits precede this one; otherwise a
  // zero best[j-1] would let a lone digit masquerade as a j-digit value.
  always_comb begin
    prev_ext = '0;
    cand     = '0;
    best_nxt[0] = '0;
    for (int j = 1; j <= K; j++) begin
      best_nxt[j] = best[j];
      prev_ext    = {4'b0000, best[j-1]};
      cand        = (prev_ext << 3) + (prev_ext << 1) + {{VAL_W{1'b0}}, s_digit};
      if (digit_ok && (cnt >= CNT_W'(j - 1)) && (cand > {4'b0000, best[j]})) begin
        best_nxt[j] = cand[VAL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      s_ready    <= 1'b0;
      bank_valid <= 1'b0;
      bank_value <= '0;
      result     <= '0;
      finished   <= 1'b0;
      error      <= 1'b0;
      cnt        <= '0;
      for (int j = 0; j <= K; j++) begin
        best[j] <= '0;
      end
    end else begin
      bank_valid <= 1'b0;
      if (bank_valid) begin
        result <= result + ACC_W'(bank_value);
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_RUN;
            s_ready  <= 1'b1;
            finished <= 1'b0;
            result   <= '0;
            error    <= 1'b0;
            cnt      <= '0;
            for (int j = 0; j <= K; j++) begin
              best[j] <= '0;
            end
          end
        end

        S_RUN: begin
          if (accept) begin
            if (!digit_ok) begin
              error <= 1'b1;
            end
            if (s_eol) begin
              // Bank complete: publish and clear so the next bank can start
              // on the very next beat.
              bank_valid <= 1'b1;
              bank_value <= short_bank ? '0 : best_nxt[K];
              if (short_bank) begin
                error <= 1'b1;
              end
              cnt <= '0;
              for (int j = 0; j <= K; j++) begin
                best[j] <= '0;
              end
              if (s_eof) begin
                state   <= S_FLUSH;
                s_ready <= 1'b0;
              end
            end else begin
              cnt <= cnt_after;
              for (int j = 0; j <= K; j++) begin
                best[j] <= best_nxt[j];
              end
            end
          end
        end

        S_FLUSH: begin
          // The last bank's value is added at the end of this cycle, so
          // result is final when finished rises.
          state    <= S_DONE;
          finished <= 1'b1;
        end

        default: begin
          state   <= S_IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lobby_joltage_stream.md
Name: lobby_joltage_stream

Overview:
- Streaming, parametrised successor to the day-3 lobby solver. Banks arrive one decimal digit per beat over a valid/ready stream.
- For each bank the block forms the largest K-digit number obtainable by choosing K digits in order, and emits that number per bank. It also accumulates the sum over all banks.
- K=2 is the part-1 case and K=12 is the part-2 case. The block sits between the input-file streamer and the result/report logic.

Parameters:
- K, 12, number of digits selected per bank (1..18).
- VAL_W, 40, width of a per-bank value; must hold 10^K-1.
- ACC_W, 48, width of the running sum.
- CNT_W, 16, width of the per-bank digit counter; the counter saturates.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that clears state and begins a run.
- s_valid  in  1  digit beat valid.
- s_ready  out  1  block accepts a beat; high only in RUN.
- s_digit  in  4  BCD digit.
- s_eol  in  1  beat is the last digit of its bank.
- s_eof  in  1  beat is the last digit of the last bank; only meaningful when s_eol=1.
- bank_valid  out  1  one-cycle pulse, bank_value is valid.
- bank_value  out  VAL_W  best K-digit value of the completed bank.
- result  out  ACC_W  running sum of bank values.
- finished  out  1  high in DONE.
- error  out  1  sticky; set on a bad digit or a short bank.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. rst overrides everything, including a mid-run reset.
- Reset values: state=IDLE. s_ready, bank_valid, finished and error are 0. bank_value and result are 0. best[0..K] and the digit counter are 0.
- Handshake: a beat transfers when s_valid && s_ready. Input signals are don't-care otherwise.
- States:
  - IDLE: s_ready=0. start -> RUN; clears result, error, best[] and the counter.
  - RUN: s_ready=1. An accepted beat with s_eol=1 and s_eof=1 -> FLUSH.
  - FLUSH: s_ready=0. Exactly one cycle, then -> DONE.
  - DONE: finished=1 and result is final. start -> RUN with full clear, same as from IDLE.
  - start in RUN or FLUSH is ignored.
- Per-digit update on an accepted beat with digit d <= 9, where n is the digits already counted in this bank:
  - for every j in 1..K with j-1 <= n, in parallel: best[j] <= max(best[j], best[j-1]*10 + d), using pre-update values.
  - best[0] is constant 0. Then n <= n+1, saturating.
  - One beat per cycle; no stall is ever required.
- Bad digit (d > 9): the beat is accepted, error is set, and no best[] or counter update occurs. s_eol/s_eof on that beat still take effect.
- End of bank: accepting a beat with s_eol in cycle t gives:
  - cycle t+1: bank_valid=1 and bank_value = best[K] including that beat's digit.
  - If n+1 < K (short bank), bank_value=0 and error is set.
  - best[] and n are cleared at the same edge, so the next bank may start in cycle t+1.
- Accumulate: result <= result + bank_value at the end of every bank_valid cycle. The sum is visible at t+2 and wraps modulo 2^ACC_W.
- bank_value holds its value until the next bank completes.
- Latency: accepting the eof beat in cycle t gives bank_valid at t+1 (FLUSH) and finished=1 with the final result at t+2.
- Arithmetic: best[j-1]*10+d is computed at VAL_W+4 bits and compared unsigned. It stays within VAL_W because 10^K-1 fits by the parameter rule.

Test Plan:
- K=2. Stream 987654321111111, 811111111111119, 234234234234278, 818181911112111 (the last with eof), no gaps -> bank_value 98, 89, 78, 92; result=357; finished two cycles after the eof beat; error=0.
- K=12, same stream -> bank_value 987654321111, 811111111119, 434234234278, 888911112111; result=3121910778619.
- K=2, same stream with random s_valid gaps -> identical results. s_ready stays 1 throughout RUN, and no beat is lost or duplicated.
- K=3, bank "12" with eol, then "999" with eof -> first bank_value=0 with error=1; second 999; result=999; error remains 1.
- K=2, digit 0xA inside bank "5A7" -> error=1, bank_value=57.
- K=2, rst asserted mid-bank then start -> all outputs 0 after rst. A fresh "91" eof bank gives result=91 with no residue from before the reset.
